// File: rtl/ama_riscv_spec_queue.sv
// In-order speculation queue tracking predicted branches from decode to execute.
// Optional hit/miss/flush statistics are enabled with `define AMA_RISCV_SPEC_STATS_EN.
module ama_riscv_spec_queue #(
  parameter int DEPTH = 4,
  parameter int PC_W  = 32
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         enq_valid,
  input  logic [PC_W-1:0]              enq_pc,
  input  logic                         enq_pred,
  output logic                         enq_ready,
  input  logic                         res_valid,
  input  logic [PC_W-1:0]              res_pc,
  input  logic                         res_outcome,
  output logic                         hit,
  output logic                         wrong,
  output logic [PC_W-1:0]              cp_pc,
  output logic                         cp_taken,
  output logic                         spec_active,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         proto_err
`ifdef AMA_RISCV_SPEC_STATS_EN
  ,
  output logic [31:0]                  stat_hit,
  output logic [31:0]                  stat_miss,
  output logic [31:0]                  stat_flushed
`endif
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("ama_riscv_spec_queue: DEPTH must be a power of 2 and >= 2");
  end

  typedef enum logic [1:0] {IDLE, SPEC, FLUSH} state_t;

  state_t            state_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [PTR_W-1:0]  rd_q, wr_q;
  logic              proto_err_q;
  logic [PC_W-1:0]   pc_mem   [DEPTH];
  logic              pred_mem [DEPTH];

  logic head_valid, resolve, enq_fire;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    head_valid  = (count_q != '0);
    cp_pc       = head_valid ? pc_mem[rd_q] : '0;
    resolve     = res_valid && head_valid && (res_pc == cp_pc);
    hit         = resolve && (res_outcome == pred_mem[rd_q]);
    wrong       = resolve && !hit;
    cp_taken    = resolve && res_outcome;
    enq_ready   = (count_q != CNT_W'(DEPTH)) && (state_q != FLUSH);
    enq_fire    = enq_valid && enq_ready;
    count_d     = count_q;
    if (enq_fire && !hit) count_d = count_q + CNT_W'(1);
    if (hit && !enq_fire) count_d = count_q - CNT_W'(1);
  end

  assign spec_active = head_valid;
  assign count       = count_q;
  assign proto_err   = proto_err_q;

  // NOTE: storage is deliberately not reset; count/pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (enq_fire && !wrong) begin
      pc_mem[wr_q]   <= enq_pc;
      pred_mem[wr_q] <= enq_pred;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      count_q     <= '0;
      rd_q        <= '0;
      wr_q        <= '0;
      proto_err_q <= 1'b0;
    end else begin
      if (res_valid && head_valid && !resolve) proto_err_q <= 1'b1;
      if (wrong) begin
        // Mispredict discards the head and everything younger, including a same-cycle enqueue.
        count_q <= '0;
        rd_q    <= '0;
        wr_q    <= '0;
        state_q <= FLUSH;
      end else begin
        count_q <= count_d;
        if (enq_fire) wr_q <= wr_q + PTR_W'(1);
        if (hit)      rd_q <= rd_q + PTR_W'(1);
        case (state_q)
          IDLE:    if (enq_fire) state_q <= SPEC;
          SPEC:    if (count_d == '0) state_q <= IDLE;
          FLUSH:   state_q <= IDLE;
          default: state_q <= IDLE;
        endcase
      end
    end
  end

`ifdef AMA_RISCV_SPEC_STATS_EN
  logic [31:0] stat_hit_q, stat_miss_q, stat_flushed_q;
  logic [32:0] flushed_sum;

  assign flushed_sum = {1'b0, stat_flushed_q} + 33'(count_q - CNT_W'(1));

  always_ff @(posedge clk) begin
    if (rst) begin
      stat_hit_q     <= '0;
      stat_miss_q    <= '0;
      stat_flushed_q <= '0;
    end else begin
      if (hit && stat_hit_q != '1) stat_hit_q <= stat_hit_q + 32'd1;
      if (wrong) begin
        if (stat_miss_q != '1) stat_miss_q <= stat_miss_q + 32'd1;
        stat_flushed_q <= flushed_sum[32] ? '1 : flushed_sum[31:0];
      end
    end
  end

  assign stat_hit     = stat_hit_q;
  assign stat_miss    = stat_miss_q;
  assign stat_flushed = stat_flushed_q;
`endif

endmodule

// File: tb/tb_ama_riscv_spec_queue.sv
// Directed self-checking bench for ama_riscv_spec_queue (default build, DEPTH=4).
module tb_ama_riscv_spec_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        enq_valid, enq_pred, enq_ready;
  logic [31:0] enq_pc, res_pc, cp_pc;
  logic        res_valid, res_outcome;
  logic        hit, wrong, cp_taken, spec_active, proto_err;
  logic [2:0]  count;

  int n_checks = 0;
  int n_errors = 0;

  ama_riscv_spec_queue #(.DEPTH(4), .PC_W(32)) dut (
    .clk(clk), .rst(rst),
    .enq_valid(enq_valid), .enq_pc(enq_pc), .enq_pred(enq_pred), .enq_ready(enq_ready),
    .res_valid(res_valid), .res_pc(res_pc), .res_outcome(res_outcome),
    .hit(hit), .wrong(wrong), .cp_pc(cp_pc), .cp_taken(cp_taken),
    .spec_active(spec_active), .count(count), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic quiet();
    enq_valid = 1'b0; enq_pc = '0; enq_pred = 1'b0;
    res_valid = 1'b0; res_pc = '0; res_outcome = 1'b0;
  endtask

  task automatic enq(input logic [31:0] pc, input logic pred);
    enq_valid = 1'b1; enq_pc = pc; enq_pred = pred;
    tick();
    enq_valid = 1'b0;
  endtask

  // Resolve the head and check the zero-latency flags before the commit edge.
  task automatic resolve(input string tag, input logic [31:0] pc, input logic outcome,
                         input logic exp_hit);
    res_valid = 1'b1; res_pc = pc; res_outcome = outcome;
    #2;
    check({tag, ".hit"}, 32'(hit), 32'(exp_hit));
    check({tag, ".wrong"}, 32'(wrong), 32'(!exp_hit));
    tick();
    res_valid = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
  endtask

  initial begin
    quiet();
    do_reset();

    // Reset state
    check("rst.count", 32'(count), 0);
    check("rst.enq_ready", 32'(enq_ready), 1);
    check("rst.spec_active", 32'(spec_active), 0);
    check("rst.proto_err", 32'(proto_err), 0);
    check("rst.cp_pc", cp_pc, 0);
    check("rst.hit", 32'(hit), 0);
    check("rst.wrong", 32'(wrong), 0);
    check("rst.cp_taken", 32'(cp_taken), 0);

    // Single hit
    enq(32'h100, 1'b1);
    check("single.count1", 32'(count), 1);
    check("single.cp_pc", cp_pc, 32'h100);
    check("single.active", 32'(spec_active), 1);
    resolve("single", 32'h100, 1'b1, 1'b1);
    check("single.count0", 32'(count), 0);
    check("single.idle", 32'(spec_active), 0);
    check("single.ready", 32'(enq_ready), 1);

    // Fill and back-pressure
    for (int i = 1; i <= 4; i++) enq(32'(i * 16), 1'b1);
    check("fill.count", 32'(count), 4);
    check("fill.ready", 32'(enq_ready), 0);
    enq(32'h50, 1'b1);
    check("fill.5th_ignored", 32'(count), 4);
    check("fill.head", cp_pc, 32'h10);
    resolve("fill.r10", 32'h10, 1'b1, 1'b1);
    check("fill.count3", 32'(count), 3);
    check("fill.cp_pc", cp_pc, 32'h20);
    check("fill.ready3", 32'(enq_ready), 1);
    resolve("fill.r20", 32'h20, 1'b1, 1'b1);
    resolve("fill.r30", 32'h30, 1'b1, 1'b1);
    resolve("fill.r40", 32'h40, 1'b1, 1'b1);
    check("fill.drained", 32'(count), 0);

    // Mispredict flush with a same-cycle enqueue that must be dropped
    enq(32'h10, 1'b0);
    enq(32'h20, 1'b0);
    enq(32'h30, 1'b0);
    check("flush.count3", 32'(count), 3);
    enq_valid = 1'b1; enq_pc = 32'h99; enq_pred = 1'b1;
    res_valid = 1'b1; res_pc = 32'h10; res_outcome = 1'b1;
    #2;
    check("flush.wrong", 32'(wrong), 1);
    check("flush.hit", 32'(hit), 0);
    check("flush.cp_taken", 32'(cp_taken), 1);
    tick();
    quiet();
    check("flush.count0", 32'(count), 0);
    check("flush.ready_low", 32'(enq_ready), 0);
    check("flush.cp_pc", cp_pc, 0);
    enq(32'h77, 1'b1);
    check("flush.enq_blocked", 32'(count), 0);
    check("flush.ready_back", 32'(enq_ready), 1);
    check("flush.idle", 32'(spec_active), 0);

    // Simultaneous enqueue + hit at count 2, six times to wrap both pointers
    enq(32'h200, 1'b1);
    enq(32'h204, 1'b0);
    for (int i = 0; i < 6; i++) begin
      enq_valid = 1'b1; enq_pc = 32'h200 + 32'((i + 2) * 4); enq_pred = ((i + 2) % 2) == 0;
      resolve($sformatf("wrap%0d", i), 32'h200 + 32'(i * 4), (i % 2) == 0, 1'b1);
      enq_valid = 1'b0;
      check($sformatf("wrap%0d.count", i), 32'(count), 2);
      check($sformatf("wrap%0d.cp_pc", i), cp_pc, 32'h200 + 32'((i + 1) * 4));
    end
    resolve("wrap.d6", 32'h218, 1'b1, 1'b1);
    resolve("wrap.d7", 32'h21c, 1'b0, 1'b1);
    check("wrap.drained", 32'(count), 0);

    // Protocol error: mismatched resolve PC is ignored and sets a sticky flag
    enq(32'h40, 1'b1);
    res_valid = 1'b1; res_pc = 32'h44; res_outcome = 1'b1;
    #2;
    check("proto.no_hit", 32'(hit), 0);
    check("proto.no_wrong", 32'(wrong), 0);
    tick();
    res_valid = 1'b0;
    check("proto.err", 32'(proto_err), 1);
    check("proto.no_pop", 32'(count), 1);
    check("proto.head", cp_pc, 32'h40);
    tick();
    check("proto.sticky", 32'(proto_err), 1);
    do_reset();
    check("proto.rst_err", 32'(proto_err), 0);
    check("proto.rst_count", 32'(count), 0);

    // Resolve against an empty queue: ignored with no flag
    res_valid = 1'b1; res_pc = 32'h0; res_outcome = 1'b1;
    #2;
    check("empty.hit", 32'(hit), 0);
    check("empty.wrong", 32'(wrong), 0);
    tick();
    res_valid = 1'b0;
    check("empty.proto", 32'(proto_err), 0);
    check("empty.count", 32'(count), 0);

    // Reset asserted during the FLUSH cycle
    enq(32'h10, 1'b0);
    resolve("rstflush", 32'h10, 1'b1, 1'b0);
    check("rstflush.in_flush", 32'(enq_ready), 0);
    do_reset();
    check("rstflush.ready", 32'(enq_ready), 1);
    check("rstflush.count", 32'(count), 0);
    enq(32'h300, 1'b1);
    check("rstflush.enq_ok", 32'(count), 1);
    check("rstflush.cp_pc", cp_pc, 32'h300);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
